// File: rtl/apb_node_timeout.sv
// APB 1-to-NB_MASTER node: range decode, PSLVERR on miss or watchdog expiry, saturating error count.
// Latency: hit = 3 cycles minimum (SETUP, ACCESS, RESP); miss = 1 cycle. Upstream waits via pready_o; new transfers are accepted only in IDLE.
module apb_node_timeout #(
  parameter int NB_MASTER      = 8,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter logic [APB_DATA_WIDTH-1:0] ERR_RDATA = 'hBADC0DE0
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0]           paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]           pwdata_i,
  input  logic                                pwrite_i,
  input  logic                                psel_i,
  input  logic                                penable_i,
  output logic [APB_DATA_WIDTH-1:0]           prdata_o,
  output logic                                pready_o,
  output logic                                pslverr_o,
  output logic [APB_ADDR_WIDTH-1:0]           paddr_o,
  output logic [APB_DATA_WIDTH-1:0]           pwdata_o,
  output logic                                pwrite_o,
  output logic [NB_MASTER-1:0]                psel_o,
  output logic                                penable_o,
  input  logic [NB_MASTER*APB_DATA_WIDTH-1:0] prdata_i,
  input  logic [NB_MASTER-1:0]                pready_i,
  input  logic [NB_MASTER-1:0]                pslverr_i,
  input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] end_addr_i,
  output logic                                timeout_o,
  output logic [7:0]                          err_cnt_o
);

  localparam int AW  = APB_ADDR_WIDTH;
  localparam int DW  = APB_DATA_WIDTH;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam int WDW = WD_EN ? (($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state;
  logic [NB_MASTER-1:0]  sel_q;
  logic [NB_MASTER-1:0]  dec_sel;
  logic                  dec_hit;
  logic [WDW-1:0]        wd_cnt;
  logic                  sel_rdy;
  logic                  sel_err;
  logic [DW-1:0]         sel_rdata;
  logic [7:0]            err_cnt_inc;

  // Lowest matching index wins; an inverted region (start > end) can never satisfy both bounds.
  always_comb begin
    dec_sel = '0;
    dec_hit = 1'b0;
    for (int k = 0; k < NB_MASTER; k++) begin
      if (!dec_hit && (start_addr_i[k*AW +: AW] <= paddr_i) && (paddr_i <= end_addr_i[k*AW +: AW])) begin
        dec_sel[k] = 1'b1;
        dec_hit    = 1'b1;
      end
    end
  end

  always_comb begin
    sel_rdy   = |(pready_i & sel_q);
    sel_err   = |(pslverr_i & sel_q);
    sel_rdata = '0;
    for (int k = 0; k < NB_MASTER; k++) begin
      if (sel_q[k]) sel_rdata = sel_rdata | prdata_i[k*DW +: DW];
    end
  end

  assign err_cnt_inc = (&err_cnt_o) ? err_cnt_o : err_cnt_o + 8'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      sel_q     <= '0;
      wd_cnt    <= '0;
      psel_o    <= '0;
      penable_o <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      pwrite_o  <= 1'b0;
      prdata_o  <= '0;
      pready_o  <= 1'b0;
      pslverr_o <= 1'b0;
      timeout_o <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      pready_o  <= 1'b0;
      pslverr_o <= 1'b0;
      prdata_o  <= '0;
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (psel_i && !penable_i) begin
            paddr_o  <= paddr_i;
            pwdata_o <= pwdata_i;
            pwrite_o <= pwrite_i;
            sel_q    <= dec_sel;
            if (dec_hit) begin
              psel_o <= dec_sel;
              state  <= SETUP;
            end else begin
              pready_o  <= 1'b1;
              pslverr_o <= 1'b1;
              prdata_o  <= ERR_RDATA;
              err_cnt_o <= err_cnt_inc;
              state     <= RESP;
            end
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          wd_cnt    <= '0;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (sel_rdy) begin
            psel_o    <= '0;
            penable_o <= 1'b0;
            pready_o  <= 1'b1;
            pslverr_o <= sel_err;
            prdata_o  <= sel_rdata;
            if (sel_err) err_cnt_o <= err_cnt_inc;
            state     <= RESP;
          end else if (WD_EN && (wd_cnt == WD_LAST)) begin
            // Last permitted wait cycle passed without ready: abort.
            psel_o    <= '0;
            penable_o <= 1'b0;
            pready_o  <= 1'b1;
            pslverr_o <= 1'b1;
            prdata_o  <= ERR_RDATA;
            timeout_o <= 1'b1;
            err_cnt_o <= err_cnt_inc;
            state     <= RESP;
          end else if (WD_EN) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_node_timeout.sv
// Directed bench for apb_node_timeout with an 8-port map and a 4-cycle watchdog.
module tb_apb_node_timeout;

  localparam int NB = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     paddr_i, pwdata_i;
  logic            pwrite_i, psel_i, penable_i;
  logic [31:0]     prdata_o;
  logic            pready_o, pslverr_o;
  logic [31:0]     paddr_o, pwdata_o;
  logic            pwrite_o;
  logic [NB-1:0]   psel_o;
  logic            penable_o;
  logic [NB*32-1:0] prdata_i;
  logic [NB-1:0]   pready_i, pslverr_i;
  logic [NB*32-1:0] start_addr_i, end_addr_i;
  logic            timeout_o;
  logic [7:0]      err_cnt_o;

  always #5 clk = ~clk;

  apb_node_timeout #(
    .NB_MASTER(NB), .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4), .ERR_RDATA(32'hBADC0DE0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pwrite_i(pwrite_i),
    .psel_i(psel_i), .penable_i(penable_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o),
    .psel_o(psel_o), .penable_o(penable_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
    .timeout_o(timeout_o), .err_cnt_o(err_cnt_o)
  );

  // Peripheral model: ready once wait_cfg ACCESS cycles have elapsed.
  logic [7:0] acc_cnt;
  logic [7:0] wait_cfg;
  logic       perr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         acc_cnt <= 8'd0;
    else if (penable_o) acc_cnt <= acc_cnt + 8'd1;
    else                acc_cnt <= 8'd0;
  end

  assign pready_i  = {NB{acc_cnt >= wait_cfg}};
  assign pslverr_i = {NB{perr}};

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] r_data;
  logic        r_err, r_to, r_resp_sel;
  logic [7:0]  r_cnt, sel_seen;
  logic [7:0]  psel_hist [16];
  logic        pen_hist  [16];
  int          r_lat, r_acc;
  int          exp_cnt;

  task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic wr);
    bit got = 1'b0;
    @(negedge clk);
    paddr_i = addr; pwdata_i = wdata; pwrite_i = wr; psel_i = 1'b1; penable_i = 1'b0;
    r_lat = 0; r_acc = 0; sel_seen = '0; r_to = 1'b0;
    r_data = '0; r_err = 1'b0; r_cnt = '0; r_resp_sel = 1'b0;
    for (int i = 1; i < 16 && !got; i++) begin
      @(negedge clk);
      penable_i    = 1'b1;
      r_lat        = i;
      psel_hist[i] = psel_o;
      pen_hist[i]  = penable_o;
      sel_seen     = sel_seen | psel_o;
      if (penable_o) r_acc++;
      if (timeout_o) r_to = 1'b1;
      if (pready_o) begin
        got        = 1'b1;
        r_data     = prdata_o;
        r_err      = pslverr_o;
        r_cnt      = err_cnt_o;
        r_resp_sel = (|psel_o) | penable_o;
      end
    end
    if (!got) chk("xfer_bound", 32'd0, 32'd1);
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  initial begin
    paddr_i = '0; pwdata_i = '0; pwrite_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
    wait_cfg = 8'd0; perr = 1'b0; exp_cnt = 0;
    for (int k = 0; k < NB; k++) begin
      prdata_i[k*32 +: 32]     = 32'hA000_0000 + k;
      start_addr_i[k*32 +: 32] = 32'hFFFF_FFFF;
      end_addr_i[k*32 +: 32]   = 32'h0000_0000;
    end
    prdata_i[1*32 +: 32]     = 32'h1234_5678;
    start_addr_i[0*32 +: 32] = 32'h1A10_0000; end_addr_i[0*32 +: 32] = 32'h1A10_0FFF;
    start_addr_i[1*32 +: 32] = 32'h1A10_1000; end_addr_i[1*32 +: 32] = 32'h1A10_1FFF;
    start_addr_i[2*32 +: 32] = 32'h1A10_0000; end_addr_i[2*32 +: 32] = 32'h1A10_0FFF;
    start_addr_i[3*32 +: 32] = 32'h1A1F_FFFF; end_addr_i[3*32 +: 32] = 32'h1A1F_0000;
    start_addr_i[4*32 +: 32] = 32'h1A10_4000; end_addr_i[4*32 +: 32] = 32'h1A10_4FFF;
    start_addr_i[5*32 +: 32] = 32'h1A10_5000; end_addr_i[5*32 +: 32] = 32'h1A10_5FFF;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_psel", psel_o, 0);
    chk("rst_penable", penable_o, 0);
    chk("rst_pready", pready_o, 0);
    chk("rst_pslverr", pslverr_o, 0);
    chk("rst_prdata", prdata_o, 0);
    chk("rst_paddr", paddr_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_errcnt", err_cnt_o, 0);
    rst_n = 1'b1;

    // Hit, zero wait
    xfer(32'h1A10_1004, 32'h0, 1'b0);
    chk("hit_lat", r_lat, 3);
    chk("hit_psel_t1", psel_hist[1], 8'h02);
    chk("hit_pen_t1", pen_hist[1], 0);
    chk("hit_pen_t2", pen_hist[2], 1);
    chk("hit_rdata", r_data, 32'h1234_5678);
    chk("hit_err", r_err, 0);
    chk("hit_resp_sel", r_resp_sel, 0);
    chk("hit_paddr", paddr_o, 32'h1A10_1004);

    // Miss: also lands inside the inverted region 3 bounds
    xfer(32'h1A1F_F000, 32'h0, 1'b0);
    exp_cnt++;
    chk("miss_lat", r_lat, 1);
    chk("miss_sel", sel_seen, 0);
    chk("miss_err", r_err, 1);
    chk("miss_rdata", r_data, 32'hBADC0DE0);
    chk("miss_cnt", r_cnt, exp_cnt);

    // Overlap priority write
    xfer(32'h1A10_0000, 32'hA5, 1'b1);
    chk("ovl_sel", sel_seen, 8'h01);
    chk("ovl_pwdata", pwdata_o, 32'hA5);
    chk("ovl_pwrite", pwrite_o, 1);
    chk("ovl_lat", r_lat, 3);

    // Region end inclusive, one past end misses
    xfer(32'h1A10_1FFF, 32'h0, 1'b0);
    chk("end_sel", sel_seen, 8'h02);
    chk("end_rdata", r_data, 32'h1234_5678);
    xfer(32'h1A10_2000, 32'h0, 1'b0);
    exp_cnt++;
    chk("past_end_err", r_err, 1);
    chk("past_end_cnt", r_cnt, exp_cnt);

    // Watchdog abort after 4 ACCESS cycles
    wait_cfg = 8'd255;
    xfer(32'h1A10_4000, 32'h0, 1'b0);
    exp_cnt++;
    chk("to_lat", r_lat, 6);
    chk("to_acc", r_acc, 4);
    chk("to_err", r_err, 1);
    chk("to_rdata", r_data, 32'hBADC0DE0);
    chk("to_pulse", r_to, 1);
    chk("to_resp_sel", r_resp_sel, 0);
    chk("to_cnt", r_cnt, exp_cnt);
    @(negedge clk);
    chk("to_pulse_end", timeout_o, 0);

    // Ready on the 4th ACCESS cycle is a normal completion
    wait_cfg = 8'd3;
    xfer(32'h1A10_4010, 32'h0, 1'b0);
    chk("rdy4_lat", r_lat, 6);
    chk("rdy4_acc", r_acc, 4);
    chk("rdy4_err", r_err, 0);
    chk("rdy4_to", r_to, 0);
    chk("rdy4_rdata", r_data, 32'hA000_0004);

    // Peripheral errors until saturation
    wait_cfg = 8'd0; perr = 1'b1;
    for (int i = 0; i < 300; i++) begin
      xfer(32'h1A10_5000, 32'h0, 1'b0);
      if (exp_cnt < 255) exp_cnt++;
      chk("perr_err", r_err, 1);
      chk("perr_cnt", r_cnt, exp_cnt);
    end
    chk("sat_cnt", err_cnt_o, 255);
    perr = 1'b0;

    // Reset while waiting in ACCESS
    wait_cfg = 8'd255;
    @(negedge clk);
    paddr_i = 32'h1A10_4000; pwrite_i = 1'b0; psel_i = 1'b1; penable_i = 1'b0;
    @(negedge clk);
    penable_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_in_access", penable_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_psel", psel_o, 0);
    chk("mid_rst_pen", penable_o, 0);
    chk("mid_rst_pready", pready_o, 0);
    chk("mid_rst_cnt", err_cnt_o, 0);
    psel_i = 1'b0; penable_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; wait_cfg = 8'd0; exp_cnt = 0;
    xfer(32'h1A10_1008, 32'h0, 1'b0);
    chk("post_rst_lat", r_lat, 3);
    chk("post_rst_rdata", r_data, 32'h1234_5678);
    chk("post_rst_err", r_err, 0);
    chk("post_rst_cnt", r_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_node_timeout.md
Name: apb_node_timeout

Overview:
- Parametrised APB 1-to-NB_MASTER peripheral node; successor to the fixed-map peripheral bus wrapper.
- Sits between the AXI-to-APB bridge and the peripherals (UART, GPIO, event unit, SoC ctrl, …).
- Adds over the current node:
  - Registered request path.
  - Priority address decode from runtime range vectors.
  - Error response (PSLVERR) for unmapped addresses.
  - Per-transfer timeout watchdog with error return.
  - Saturating error counter.

Parameters:
- NB_MASTER, 8, number of downstream peripheral ports (1..32).
- APB_ADDR_WIDTH, 32, address width.
- APB_DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 256, max ACCESS cycles before abort; 0 disables the watchdog.
- ERR_RDATA, 32'hBADC0DE0, read data returned on any node-generated error.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- paddr_i  in  APB_ADDR_WIDTH  upstream address.
- pwdata_i  in  APB_DATA_WIDTH  upstream write data.
- pwrite_i  in  1  upstream write flag.
- psel_i  in  1  upstream select.
- penable_i  in  1  upstream enable.
- prdata_o  out  APB_DATA_WIDTH  upstream read data.
- pready_o  out  1  upstream ready.
- pslverr_o  out  1  upstream error.
- paddr_o  out  APB_ADDR_WIDTH  shared downstream address (registered).
- pwdata_o  out  APB_DATA_WIDTH  shared downstream write data (registered).
- pwrite_o  out  1  shared downstream write flag (registered).
- psel_o  out  NB_MASTER  one-hot downstream select.
- penable_o  out  1  shared downstream enable.
- prdata_i  in  NB_MASTER*APB_DATA_WIDTH  per-port read data; port k occupies bits [k*DW +: DW].
- pready_i  in  NB_MASTER  per-port ready.
- pslverr_i  in  NB_MASTER  per-port error.
- start_addr_i  in  NB_MASTER*APB_ADDR_WIDTH  inclusive region start, per port.
- end_addr_i  in  NB_MASTER*APB_ADDR_WIDTH  inclusive region end, per port.
- timeout_o  out  1  one-cycle pulse when a transfer is aborted by the watchdog.
- err_cnt_o  out  8  saturating count of all error responses returned upstream.

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - FSM to IDLE.
  - psel_o=0, penable_o=0, paddr_o/pwdata_o/prdata_o=0, pwrite_o=0.
  - pready_o=0, pslverr_o=0, timeout_o=0, err_cnt_o=0.
  - Watchdog counter=0.
  - Reset mid-transfer drops downstream select immediately; no response is returned upstream.
- Decode (combinational on paddr_i):
  - Port k matches when start_k <= paddr_i <= end_k (unsigned compare).
  - Lowest matching index wins.
  - A region with start > end never matches.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On psel_i=1 and penable_i=0: latch paddr/pwdata/pwrite, latch decode result into sel_q (one-hot) and a miss flag.
  - Next state: SETUP if hit, RESP with error if miss.
- SETUP: psel_o=sel_q, penable_o=0. Next state ACCESS.
- ACCESS:
  - psel_o=sel_q, penable_o=1.
  - Watchdog counts ACCESS cycles with the selected pready_i=0.
  - Selected pready_i=1: capture the selected prdata_i and pslverr_i into response registers; go to RESP.
  - No ready by the TIMEOUT_CYCLES-th ACCESS cycle: go to RESP with pslverr=1, prdata=ERR_RDATA; pulse timeout_o in the RESP cycle.
  - Ready on the TIMEOUT_CYCLES-th cycle itself counts as a normal completion, not a timeout.
- RESP (exactly one cycle):
  - pready_o=1; prdata_o/pslverr_o come from the response registers.
  - Miss response: prdata_o=ERR_RDATA, pslverr_o=1.
  - psel_o=0, penable_o=0. Next state IDLE.
- pready_o is 0 in all states other than RESP.
- Back-to-back: a new upstream SETUP is accepted only in IDLE. Minimum latency from upstream SETUP to pready_o = 3 cycles for a hit with zero-wait-state peripheral, 1 cycle for a miss.
- Upstream protocol violations (psel_i dropped or paddr_i changed mid-transfer): ignored; the latched transfer completes.
- err_cnt_o: +1 on each RESP cycle with pslverr_o=1 (miss, timeout, or peripheral error); saturates at 255.
- Watchdog counter clears on every entry to ACCESS. It is sized $clog2(TIMEOUT_CYCLES+1) bits, minimum 1.
- Unselected ports' pready_i/pslverr_i/prdata_i are ignored.

Test Plan:
- Hit, zero wait: region1=0x1A101000..0x1A101FFF, read 0x1A101004, port1 pready_i=1 prdata=0x12345678.
  -> psel_o=0b10 at T+1, penable_o at T+2, pready_o at T+3 with prdata_o=0x12345678, pslverr_o=0.
- Miss: read 0x1A1FF000 outside all regions.
  -> no psel_o bit ever set; pready_o at T+1, pslverr_o=1, prdata_o=0xBADC0DE0, err_cnt_o=1.
- Overlap priority: region0 and region2 both cover 0x1A100000, write 0xA5.
  -> psel_o=0b001 only; pwdata_o=0xA5, pwrite_o=1.
- Timeout: TIMEOUT_CYCLES=4, selected port holds pready_i=0.
  -> 4 ACCESS cycles, then RESP with pslverr_o=1, timeout_o pulses for 1 cycle, psel_o=0 in RESP.
  -> Same config with ready on 4th ACCESS cycle -> normal response, no timeout_o.
- Peripheral error and saturation: 300 transfers with pslverr_i=1.
  -> each RESP has pslverr_o=1; err_cnt_o stops at 255.
- Reset mid-ACCESS: rst_ni low during wait.
  -> psel_o/penable_o/pready_o=0 asynchronously; the next transfer after release completes normally.
